lcd_write_scheduler: RTL
========================

Name: lcd_write_scheduler

Overview:
Sequences and shares the 8-bit HD44780-style character LCD between two requesters, for example the ADC readout and the robot status display.
- Runs the power-up initialisation sequence on its own.
- Then round-robin arbitrates single-byte command/data writes from the two requesters.
- Generates RS/EN/DATA timing and the post-write busy waits itself, so no LCD busy-flag readback is used.
- Sits between the requesters and the board-level LCD pins; the top level forwards its outputs to LCD_DATA/LCD_EN/LCD_RS/LCD_RW and ties LCD_ON high.

Parameters:
EN_HIGH_CYC, 25, EN high width in iCLK cycles (500 ns at 50 MHz)
CMD_WAIT_CYC, 2500, wait after an ordinary command/data write (50 us)
CLR_WAIT_CYC, 100000, wait after clear (0x01) or home (0x02/0x03) with RS=0 (2 ms)
PWRUP_WAIT_CYC, 1000000, delay after reset before the first init command (20 ms)

Ports:
iCLK  in  1  system clock, 50 MHz
iRST_N  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a byte to write
req0_rs  in  1  requester 0 register select: 0=command, 1=data
req0_data  in  8  requester 0 byte
req0_ready  out  1  requester 0 byte accepted this cycle
req1_valid / req1_rs / req1_data / req1_ready  as req0, for requester 1
LCD_DATA  out  8  LCD data bus
LCD_RS  out  1  LCD register select
LCD_EN  out  1  LCD enable strobe
LCD_RW  out  1  constant 0 (write only)
init_done  out  1  high once the init sequence completes; stays high until reset
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (async, iRST_N=0):
  - State = PWRUP; counter = 0; rr_last = 1 (requester 0 wins first).
  - LCD_EN=0, LCD_RS=0, LCD_DATA=8'h00, LCD_RW=0.
  - init_done=0, busy=1, req*_ready=0.
  - Reset mid-strobe drops EN the same instant; no write completes.
- States:
  - PWRUP: count PWRUP_WAIT_CYC cycles, then go to INIT_ISSUE with init index 0.
  - INIT_ISSUE: load the init ROM entry (RS=0), then go to SETUP. ROM order: 0x38, 0x0C, 0x01, 0x06.
  - SETUP: 1 cycle; RS/DATA stable, EN=0.
  - EN_HI: EN=1 for exactly EN_HIGH_CYC cycles; RS/DATA held.
  - HOLD: 1 cycle; EN=0, RS/DATA held.
  - WAIT: count CLR_WAIT_CYC if RS=0 and DATA in {0x01,0x02,0x03}, else CMD_WAIT_CYC.
  - After WAIT during init: go to the next ROM entry; after the last entry, set init_done and go to IDLE.
  - After WAIT otherwise: go to IDLE.
  - IDLE: busy=0. RS/DATA keep the last values; EN=0.
- Arbitration (IDLE with init_done only):
  - grant = the single valid requester.
  - If both are valid, grant the requester that is not rr_last.
  - reqN_ready = (state==IDLE) & init_done & (grant==N); combinational.
- Handshake:
  - A transfer occurs on a rising edge with reqN_valid & reqN_ready.
  - On transfer: latch rs/data, set rr_last=N, go to SETUP.
  - Requesters hold valid/rs/data stable until ready; valid may drop without a transfer.
  - Requests made before init_done are held off (ready=0), not dropped.
- Latency and throughput:
  - The accept edge puts the byte on LCD_DATA in the next cycle.
  - EN rises 1 cycle after SETUP.
  - Back-to-back accepts are spaced 1+EN_HIGH_CYC+1+wait+1 cycles apart (IDLE counts as 1 cycle).
  - With defaults, ordinary writes are 2528 cycles apart.
- Counter: one shared down- or up-counter, 21 bits (covers 1,000,000). Each state reloads or clears it on entry. Wrap-around never occurs.

Decomposition:
- Shared package lcd_pkg: state enum; init ROM constants (LCD_FUNC_8BIT_2L=8'h38, LCD_DISP_ON=8'h0C, LCD_CLEAR=8'h01, LCD_ENTRY_INC=8'h06, INIT_LEN=4); default timing constants.
- One sub-module, lcd_rr_arbiter: 2-input round-robin grant from valid and rr_last, purely combinational plus the rr_last register.

Test Plan:
- Init sequence: release reset, no requests -> nothing on the bus before 1,000,000 cycles; then 4 EN pulses, each exactly 25 cycles, with DATA 0x38, 0x0C, 0x01, 0x06 and RS=0. Gap after 0x01 is ≥100000 cycles; init_done rises after the last wait; no ready asserted before that.
- Single write: after init, req0 = valid, rs=1, data 0x41 -> req0_ready for 1 cycle; RS=1 and DATA=0x41 the next cycle; EN high 25 cycles; busy low again 2528 cycles after accept.
- Contention: req0 and req1 both held valid with bytes 0x30 and 0x31 for 4 transfers each -> grants alternate 0, 1, 0, 1…, starting with 0.
- Clear timing: req1 sends rs=0, data 0x01 -> next ready comes ≥100000 cycles after HOLD. Same for rs=1, data 0x01 -> 2500-cycle wait only.
- Reset mid-operation: assert iRST_N=0 in cycle 10 of EN_HI -> EN, RS, DATA go to 0 immediately and init_done=0; after release, the full PWRUP/INIT sequence repeats.
- Early request: req0 valid with 0x55 during PWRUP -> ready stays 0 until after init_done, then 0x55 is written once.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared states, init ROM and timing defaults for the LCD write scheduler
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_PWRUP,
      ST_INIT_ISSUE,
      ST_SETUP,
      ST_EN_HI,
      ST_HOLD,
      ST_WAIT,
      ST_IDLE
   } lcd_state_e;

   localparam int CNT_W = 21;

   localparam logic [7:0] LCD_FUNC_8BIT_2L = 8'h38;
   localparam logic [7:0] LCD_DISP_ON      = 8'h0C;
   localparam logic [7:0] LCD_CLEAR        = 8'h01;
   localparam logic [7:0] LCD_ENTRY_INC    = 8'h06;
   localparam int         INIT_LEN         = 4;

   localparam int DEF_EN_HIGH_CYC    = 25;
   localparam int DEF_CMD_WAIT_CYC   = 2500;
   localparam int DEF_CLR_WAIT_CYC   = 100000;
   localparam int DEF_PWRUP_WAIT_CYC = 1000000;

   function automatic logic [7:0] init_rom(input logic [1:0] idx);
      case (idx)
         2'd0:    init_rom = LCD_FUNC_8BIT_2L;
         2'd1:    init_rom = LCD_DISP_ON;
         2'd2:    init_rom = LCD_CLEAR;
         default: init_rom = LCD_ENTRY_INC;
      endcase
   endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// rtl/lcd_rr_arbiter.sv - two-requester round-robin grant with its rr_last register
module lcd_rr_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] valid,
   output logic [1:0] ready,
   output logic       grant
);

   logic rr_last;

   always_comb begin
      grant = 1'b0;
      case (valid)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~rr_last;
         default: grant = 1'b0;
      endcase
      ready = 2'b00;
      if (en && (valid != 2'b00))
         ready = grant ? 2'b10 : 2'b01;
   end

   // Reset to 1 so requester 0 wins the first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rr_last <= 1'b1;
      else if (|(valid & ready))
         rr_last <= grant;
   end

endmodule

// File: rtl/lcd_write_scheduler.sv
// rtl/lcd_write_scheduler.sv - HD44780 init sequencer and shared write scheduler for two requesters
module lcd_write_scheduler
   import lcd_pkg::*;
#(
   parameter int EN_HIGH_CYC    = DEF_EN_HIGH_CYC,
   parameter int CMD_WAIT_CYC   = DEF_CMD_WAIT_CYC,
   parameter int CLR_WAIT_CYC   = DEF_CLR_WAIT_CYC,
   parameter int PWRUP_WAIT_CYC = DEF_PWRUP_WAIT_CYC
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       req0_valid,
   input  logic       req0_rs,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic       req1_rs,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic [7:0] LCD_DATA,
   output logic       LCD_RS,
   output logic       LCD_EN,
   output logic       LCD_RW,
   output logic       init_done,
   output logic       busy
);

   localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_WAIT_CYC - 1);

   lcd_state_e       state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [1:0]       init_idx, init_idx_d;
   logic             init_done_d;
   logic             rs_q, rs_d;
   logic [7:0]       data_q, data_d;
   logic [1:0]       ready;
   logic             grant;
   logic             xfer;
   logic             clr_wait;

   lcd_rr_arbiter u_arb (
      .clk   (iCLK),
      .rst_n (iRST_N),
      .en    ((state == ST_IDLE) && init_done),
      .valid ({req1_valid, req0_valid}),
      .ready (ready),
      .grant (grant)
   );

   assign req0_ready = ready[0];
   assign req1_ready = ready[1];
   assign xfer       = |(ready & {req1_valid, req0_valid});

   // Clear and home are the slow instructions; everything else gets the short wait.
   assign clr_wait = !rs_q && (data_q inside {8'h01, 8'h02, 8'h03});

   always_comb begin
      state_d     = state;
      cnt_d       = cnt + CNT_W'(1);
      init_idx_d  = init_idx;
      init_done_d = init_done;
      rs_d        = rs_q;
      data_d      = data_q;
      case (state)
         ST_PWRUP: begin
            if (cnt == PWRUP_LAST) begin
               state_d    = ST_INIT_ISSUE;
               init_idx_d = 2'd0;
            end
         end
         ST_INIT_ISSUE: begin
            rs_d    = 1'b0;
            data_d  = init_rom(init_idx);
            state_d = ST_SETUP;
         end
         ST_SETUP: state_d = ST_EN_HI;
         ST_EN_HI: begin
            if (cnt == EN_LAST)
               state_d = ST_HOLD;
         end
         ST_HOLD: state_d = ST_WAIT;
         ST_WAIT: begin
            if (cnt == (clr_wait ? CLR_LAST : CMD_LAST)) begin
               if (init_done) begin
                  state_d = ST_IDLE;
               end else if (init_idx == 2'(INIT_LEN - 1)) begin
                  init_done_d = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  init_idx_d = init_idx + 2'd1;
                  state_d    = ST_INIT_ISSUE;
               end
            end
         end
         ST_IDLE: begin
            cnt_d = cnt;
            if (xfer) begin
               rs_d    = grant ? req1_rs : req0_rs;
               data_d  = grant ? req1_data : req0_data;
               state_d = ST_SETUP;
            end
         end
         default: state_d = ST_PWRUP;
      endcase
      if (state_d != state)
         cnt_d = '0;
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state     <= ST_PWRUP;
         cnt       <= '0;
         init_idx  <= 2'd0;
         init_done <= 1'b0;
         rs_q      <= 1'b0;
         data_q    <= 8'h00;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         init_idx  <= init_idx_d;
         init_done <= init_done_d;
         rs_q      <= rs_d;
         data_q    <= data_d;
      end
   end

   assign LCD_EN   = (state == ST_EN_HI);
   assign LCD_RS   = rs_q;
   assign LCD_DATA = data_q;
   assign LCD_RW   = 1'b0;
   assign busy     = (state != ST_IDLE);

endmodule
